clk_period_meter: RTL and testbench

Measures a slow, asynchronous periodic signal, such as the output of the design's clock dividers, in units of the system clock.
- Reports, once per signal period:
  - the period in clk cycles;
  - the high-time in clk cycles.
- Flags a timeout when the signal stops toggling.
- Used as the self-check and monitor counterpart of the divider chain, feeding display and status logic.

---
 rtl/clk_period_meter_pkg.sv | 6 +
 rtl/clk_period_meter_sync_edge_det.sv | 24 ++
 rtl/clk_period_meter.sv | 86 ++++++++
 tb/tb_clk_period_meter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: shared FSM encoding and system-clock defaults for the meter and dividers
package clk_period_meter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;
  localparam int CNT_W_DEF = 28;
  localparam int TIMEOUT_DEF = 100000000;
endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: synchronizes async_in through SYNC_STAGES flops; level_out is the synced level, rise_out its one-cycle rising edge
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_out
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign level_out = r_sync[SYNC_STAGES-1];
  assign rise_out = level_out & ~r_prev;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period/high-time of sig_in in clk cycles (period_out, high_out, valid pulse), flags timeout, busy while measuring
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pcnt, r_hcnt, r_period, r_high;
  logic [CNT_W-1:0] w_pcnt_nxt, w_hcnt_nxt, w_period_nxt, w_high_nxt;
  logic r_valid, r_timeout, w_valid_nxt, w_timeout_nxt, w_level, w_rise;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .level_out(w_level),
    .rise_out (w_rise)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pcnt    <= '0;
      r_hcnt    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  always_comb begin
    w_state_nxt   = r_state;
    w_pcnt_nxt    = r_pcnt;
    w_hcnt_nxt    = r_hcnt;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    if (r_state == ST_IDLE) begin
      if (w_rise) begin
        w_state_nxt = ST_MEASURE;
        w_pcnt_nxt  = ONE;
        w_hcnt_nxt  = ONE;
      end
    end else if (w_rise) begin
      w_period_nxt  = r_pcnt;
      w_high_nxt    = r_hcnt;
      w_valid_nxt   = 1'b1;
      w_timeout_nxt = 1'b0;
      w_pcnt_nxt    = ONE;
      w_hcnt_nxt    = ONE;
    end else if (r_pcnt == TO) begin
      w_state_nxt   = ST_IDLE;
      w_timeout_nxt = 1'b1;
      w_period_nxt  = '0;
      w_high_nxt    = '0;
    end else begin
      w_pcnt_nxt = r_pcnt + ONE;
      w_hcnt_nxt = r_hcnt + CNT_W'(w_level);
    end
  end
  assign period_out = r_period;
  assign high_out   = r_high;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign busy       = (r_state == ST_MEASURE);
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed self-checking bench for clk_period_meter with CNT_W=16, TIMEOUT=64
module tb_clk_period_meter;
  localparam int CNT_W = 16;
  localparam int TIMEOUT = 64;
  logic clk, reset, sig_in, valid, timeout, busy;
  logic [CNT_W-1:0] period_out, high_out;
  int n_vec, n_err, n_valid, since_valid, to_at;
  logic [CNT_W-1:0] cap_p, cap_h;
  logic prev_to;
  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic v);
    @(posedge clk);
    #1 sig_in = v;
    @(negedge clk);
    since_valid = valid ? 0 : since_valid + 1;
    if (valid) begin
      n_valid++;
      cap_p = period_out;
      cap_h = high_out;
      chk("valid_high_le_period", 32'(high_out <= period_out), 1);
      chk("valid_high_nonzero", 32'(high_out >= 1), 1);
    end
    if (timeout && !prev_to) to_at = since_valid;
    prev_to = timeout;
  endtask
  task automatic wave(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) tick(i < hi);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_high"}, high_out, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    n_vec = 0; n_err = 0; n_valid = 0; since_valid = 0; to_at = -1; prev_to = 1'b0;
    reset = 1'b1; sig_in = 1'b0;
    repeat (3) tick(0);
    chk_zero("reset");
    reset = 1'b0;
    // square 10/5: first rise never reports
    wave(10, 5, 1);
    chk("first_edge_no_valid", n_valid, 0);
    chk("first_edge_busy", busy, 1);
    n_valid = 0;
    wave(10, 5, 5);
    chk("sq10_valid_count", n_valid, 5);
    chk("sq10_period", cap_p, 10);
    chk("sq10_high", cap_h, 5);
    chk("sq10_timeout", timeout, 0);
    chk("sq10_busy", busy, 1);
    // duty changes
    n_valid = 0;
    wave(20, 3, 3);
    chk("p20_valid_count", n_valid, 3);
    chk("p20_period", cap_p, 20);
    chk("p20_high", cap_h, 3);
    wave(12, 1, 3);
    chk("p12_period", cap_p, 12);
    chk("p12_high", cap_h, 1);
    // stop toggling low
    wave(10, 5, 4);
    chk("pre_stop_period", cap_p, 10);
    n_valid = 0; to_at = -1;
    repeat (70) tick(0);
    chk("stuck0_timeout_cycle", to_at, TIMEOUT);
    chk("stuck0_timeout", timeout, 1);
    chk("stuck0_period", period_out, 0);
    chk("stuck0_high", high_out, 0);
    chk("stuck0_busy", busy, 0);
    chk("stuck0_no_valid", n_valid, 0);
    // recovery: first rise keeps timeout, second clears it
    wave(10, 5, 1);
    chk("recover1_timeout", timeout, 1);
    chk("recover1_no_valid", n_valid, 0);
    chk("recover1_busy", busy, 1);
    wave(10, 5, 1);
    chk("recover2_valid_count", n_valid, 1);
    chk("recover2_period", cap_p, 10);
    chk("recover2_high", cap_h, 5);
    chk("recover2_timeout", timeout, 0);
    // reset mid-period
    wave(10, 5, 2);
    for (int i = 0; i < 6; i++) tick(i < 5);
    reset = 1'b1;
    tick(0); tick(0);
    chk_zero("midreset");
    reset = 1'b0;
    n_valid = 0;
    repeat (4) tick(0);
    wave(10, 5, 1);
    chk("postreset_first_no_valid", n_valid, 0);
    wave(10, 5, 1);
    chk("postreset_valid_count", n_valid, 1);
    chk("postreset_period", cap_p, 10);
    chk("postreset_high", cap_h, 5);
    // stuck high, already 1 at reset release
    reset = 1'b1;
    tick(1); tick(1);
    chk_zero("reset_hi");
    reset = 1'b0;
    n_valid = 0;
    repeat (60) tick(1);
    chk("stuck1_busy_before", busy, 1);
    chk("stuck1_no_timeout_yet", timeout, 0);
    repeat (20) tick(1);
    chk("stuck1_no_valid", n_valid, 0);
    chk("stuck1_timeout", timeout, 1);
    chk("stuck1_period", period_out, 0);
    chk("stuck1_high", high_out, 0);
    chk("stuck1_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
